pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 126 ++++++++++++
 tb/tb_pc_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT control, prioritised redirects, trap capture.
// Optional macro BRANCH_DELAY_SLOT_EN defers redirects by one fetch (delay slot).
`timescale 1ns/1ps
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic        exception,
    input  logic        halt,
    output logic [31:0] PC,
    output logic [31:0] nextPC,
    output logic        pc_valid,
    output logic [31:0] epc,
    output logic        halted
);

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [31:0] seq_pc, br_tgt, j_tgt, redir_tgt;
    logic        redir, jr_bad, epc_we;
`ifdef BRANCH_DELAY_SLOT_EN
    logic        pend_vld, pend_set, pend_clr;
    logic [31:0] pend_tgt;
`endif

    always_comb begin
        seq_pc = PC + 32'd4;
        br_tgt = seq_pc + (branch_offset << 2);
        j_tgt  = {seq_pc[31:28], jump_target, 2'b00};
        redir  = jr | jump | branch_taken;
        if (jr)
            redir_tgt = jr_addr;
        else if (jump)
            redir_tgt = j_tgt;
        else
            redir_tgt = br_tgt;
        jr_bad = jr && (jr_addr[1:0] != 2'b00);
    end

    // Halt wins over stall and redirects but not over a trap; the halting edge keeps PC.
    always_comb begin
        state_nxt = state;
        nextPC    = PC;
        epc_we    = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
`endif
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (exception) begin
                    nextPC = EXC_VEC;
                    epc_we = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
                    pend_clr = 1'b1;
`endif
                end else if (halt) begin
                    state_nxt = HALT;
                end else if (stall) begin
                    nextPC = PC;
`ifdef BRANCH_DELAY_SLOT_EN
                end else if (pend_vld) begin
                    nextPC   = pend_tgt;
                    pend_clr = 1'b1;
`endif
                end else if (jr_bad) begin
                    nextPC = EXC_VEC;
                    epc_we = 1'b1;
                end else if (redir) begin
`ifdef BRANCH_DELAY_SLOT_EN
                    nextPC   = seq_pc;
                    pend_set = 1'b1;
`else
                    nextPC   = redir_tgt;
`endif
                end else begin
                    nextPC = seq_pc;
                end
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
            PC    <= RESET_VEC;
            epc   <= 32'h0000_0000;
        end else begin
            state <= state_nxt;
            PC    <= nextPC;
            if (epc_we)
                epc <= PC;
        end
    end

`ifdef BRANCH_DELAY_SLOT_EN
    // Redirect target waits here while the delay-slot instruction is fetched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_vld <= 1'b0;
            pend_tgt <= 32'h0000_0000;
        end else if (pend_clr) begin
            pend_vld <= 1'b0;
        end else if (pend_set) begin
            pend_vld <= 1'b1;
            pend_tgt <= redir_tgt;
        end
    end
`endif

    assign pc_valid = (state == RUN);
    assign halted   = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the sequencing rules.
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC   = 32'h0000_0080;
    localparam int ST_BOOT = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_HALT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall, branch_taken, jump, jr, exception, halt;
    logic [31:0] branch_offset, jr_addr;
    logic [25:0] jump_target;
    logic [31:0] PC, nextPC, epc;
    logic        pc_valid, halted;

    int errs = 0;
    int checks = 0;

    int          m_st, n_st;
    logic [31:0] m_pc, m_epc, m_tgt, n_pc, n_epc, n_tgt;
    bit          m_pend, n_pend;

    pc_sequencer #(.RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
        .jr(jr), .jr_addr(jr_addr), .exception(exception), .halt(halt),
        .PC(PC), .nextPC(nextPC), .pc_valid(pc_valid), .epc(epc), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = ST_BOOT; m_pc = RESET_VEC; m_epc = 32'h0; m_pend = 0; m_tgt = 32'h0;
    endtask

    // Next architectural state from the sequencing rules, in plain arithmetic.
    task automatic model_eval();
        logic [31:0] seq, tgt;
        bit go;
        n_st = m_st; n_pc = m_pc; n_epc = m_epc; n_pend = m_pend; n_tgt = m_tgt;
        seq = m_pc + 32'd4;
        go = 0;
        tgt = seq;
        if (m_st == ST_BOOT) begin
            n_st = ST_RUN;
        end else if (m_st == ST_RUN) begin
            if (exception) begin
                n_pc = EXC_VEC; n_epc = m_pc; n_pend = 0;
            end else if (halt) begin
                n_st = ST_HALT;
            end else if (stall) begin
                n_pc = m_pc;
`ifdef BRANCH_DELAY_SLOT_EN
            end else if (m_pend) begin
                n_pc = m_tgt; n_pend = 0;
`endif
            end else if (jr && (jr_addr % 4 != 0)) begin
                n_pc = EXC_VEC; n_epc = m_pc;
            end else begin
                if (jr) begin
                    go = 1; tgt = jr_addr;
                end else if (jump) begin
                    go = 1; tgt = (seq & 32'hF000_0000) + {6'd0, jump_target} * 32'd4;
                end else if (branch_taken) begin
                    go = 1; tgt = seq + branch_offset * 32'd4;
                end
                n_pc = seq;
`ifdef BRANCH_DELAY_SLOT_EN
                if (go) begin n_pend = 1; n_tgt = tgt; end
`else
                if (go) n_pc = tgt;
`endif
            end
        end
    endtask

    // Called at a negedge with inputs already applied; ends at the next negedge.
    task automatic tick();
        #1;
        model_eval();
        chk("nextPC", nextPC, n_pc);
        chk("PC", PC, m_pc);
        chk("epc", epc, m_epc);
        chk("pc_valid", {31'b0, pc_valid}, 32'(m_st == ST_RUN));
        chk("halted", {31'b0, halted}, 32'(m_st == ST_HALT));
        @(posedge clk);
        m_st = n_st; m_pc = n_pc; m_epc = n_epc; m_pend = n_pend; m_tgt = n_tgt;
        @(negedge clk);
    endtask

    task automatic set_idle();
        stall = 0; branch_taken = 0; branch_offset = 32'h0; jump = 0; jump_target = 26'h0;
        jr = 0; jr_addr = 32'h0; exception = 0; halt = 0;
    endtask

    task automatic rand_inputs();
        stall         = ($urandom % 5) == 0;
        branch_taken  = ($urandom % 3) == 0;
        branch_offset = ($urandom_range(1) == 1) ? $urandom : (32'($urandom_range(63)) - 32'd32);
        jump          = ($urandom % 5) == 0;
        jump_target   = 26'($urandom);
        jr            = ($urandom % 5) == 0;
        jr_addr       = (($urandom % 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
        exception     = ($urandom % 10) == 0;
        halt          = ($urandom % 30) == 0;
    endtask

    task automatic goto_pc(input logic [31:0] a);
        set_idle(); jr = 1; jr_addr = a;
        tick();
        set_idle();
`ifdef BRANCH_DELAY_SLOT_EN
        tick();
`endif
    endtask

    task automatic do_reset();
        reset = 1;
        model_reset();
        #1;
        chk("rst_pc", PC, RESET_VEC);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        set_idle();
        model_reset();
        @(negedge clk);
        #1;
        chk("reset_pc", PC, RESET_VEC);
        chk("reset_epc", epc, 32'h0);
        chk("reset_valid", {31'b0, pc_valid}, 32'h0);
        chk("reset_halted", {31'b0, halted}, 32'h0);
        @(negedge clk);
        reset = 0;

        // Boot then straight-line fetch: 0, 0, 4, 8, 12, 16
        repeat (4) tick();
        chk("seq_pc12", PC, 32'h0000_000C);
        chk("seq_valid", {31'b0, pc_valid}, 32'h1);
        tick();
        chk("seq_pc16", PC, 32'h0000_0010);

        // Backward branch from 0x10
        branch_taken = 1; branch_offset = 32'hFFFF_FFFE;
        tick();
        set_idle();
`ifdef BRANCH_DELAY_SLOT_EN
        chk("br_slot", PC, 32'h0000_0014);
        tick();
`endif
        chk("br_tgt", PC, 32'h0000_000C);

        // Jump, then misaligned jr traps
        goto_pc(32'h1000_0040);
        jump = 1; jump_target = 26'h100;
        tick();
        set_idle();
`ifdef BRANCH_DELAY_SLOT_EN
        tick();
`endif
        chk("jump_tgt", PC, 32'h1000_0400);
        jr = 1; jr_addr = 32'h0000_0202;
        tick();
        set_idle();
        chk("jr_bad_pc", PC, EXC_VEC);
        chk("jr_bad_epc", epc, 32'h1000_0400);

        // Stall holds PC; exception overrides stall
        goto_pc(32'h0000_0020);
        stall = 1;
        repeat (3) tick();
        chk("stall_pc", PC, 32'h0000_0020);
        exception = 1;
        tick();
        set_idle();
        chk("exc_pc", PC, EXC_VEC);
        chk("exc_epc", epc, 32'h0000_0020);

        // Halt freezes everything until reset
        goto_pc(32'h0000_0030);
        halt = 1;
        tick();
        chk("halt_flag", {31'b0, halted}, 32'h1);
        chk("halt_pc", PC, 32'h0000_0030);
        chk("halt_valid", {31'b0, pc_valid}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            rand_inputs();
            tick();
        end
        chk("halt_hold", PC, 32'h0000_0030);
        set_idle();
        #3 reset = 1;
        #1;
        chk("async_rst_pc", PC, RESET_VEC);
        chk("async_rst_halted", {31'b0, halted}, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 0;

        // Address wrap
        tick();
        goto_pc(32'hFFFF_FFFC);
        tick();
        chk("wrap_pc", PC, 32'h0000_0000);

        // Randomized traffic with periodic resets
        for (int i = 0; i < 400; i++) begin
            if (i % 60 == 0) begin
                set_idle();
                do_reset();
            end
            rand_inputs();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
